// File: rtl/fwrisc_bus_pkg.sv
// Shared types for the fwrisc memory arbiter: FSM state and bus owner
// encodings, plus small helpers used by the arbiter and its wait timer.
package fwrisc_bus_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    // Which requester owns (or last owned) the shared bus
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Width of the wait counter; covers the full TIMEOUT_CYCLES range
    localparam int unsigned WAIT_CNT_W = 16;

    // Instruction fetches always read a whole word
    localparam logic [3:0] STRB_ALL = 4'hf;

    // Owner implied by a grant state (IDLE maps to OWN_I; callers only use it in grant states)
    function automatic owner_e owner_of(input arb_state_e s);
        return (s == GNT_D) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/fwrisc_bus_timeout.sv
// Wait counter for a granted bus transaction. Counts cycles spent waiting
// for m_ready and flags the cycle in which the wait budget is used up.
// The expired flag is registered: it is computed from the next count value
// so it lines up with the cycle in which the count equals the limit.
module fwrisc_bus_timeout
    import fwrisc_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_CNT_W-1:0] count_r;

    // Wait counter and limit flag; clear wins, count stops once the limit is hit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {WAIT_CNT_W{1'b0}};
            expired <= 1'b0;
        end else if (clr) begin
            count_r <= {WAIT_CNT_W{1'b0}};
            expired <= 1'b0;
        end else if (en && !expired) begin
            count_r <= count_r + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
            expired <= ((count_r + {{(WAIT_CNT_W-1){1'b0}}, 1'b1}) == LIMIT);
        end else begin
            count_r <= count_r;
            expired <= expired;
        end
    end

endmodule

// File: rtl/fwrisc_mem_arb.sv
// Two-requester memory arbiter for fwrisc: instruction bus and data bus share
// one memory port. Round-robin on simultaneous requests, one-cycle arbitration
// latency, request fields latched at grant, completion pulses driven
// combinationally from m_ready, and a per-transaction wait timeout.
module fwrisc_mem_arb
    import fwrisc_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter bit          DBUS_FIRST     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] iaddr,
    input  logic        ivalid,
    output logic [31:0] irdata,
    output logic        iready,
    output logic        ierr,
    input  logic [31:0] daddr,
    input  logic        dvalid,
    input  logic        dwrite,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dstrb,
    output logic [31:0] drdata,
    output logic        dready,
    output logic        derr,
    output logic [31:0] m_addr,
    output logic        m_valid,
    output logic        m_write,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_strb,
    input  logic [31:0] m_rdata,
    input  logic        m_ready
);

    // Seeding last-grant with the opposite owner makes the preferred side win first
    localparam owner_e RESET_LAST = DBUS_FIRST ? OWN_I : OWN_D;

    arb_state_e state_r;
    arb_state_e next_state_s;
    owner_e     last_r;
    logic       grant_i_s;
    logic       grant_d_s;
    logic       done_s;
    logic       expired_s;
    logic       wait_clr_s;
    logic       wait_en_s;

    assign wait_clr_s = (state_r == IDLE);
    assign wait_en_s  = (state_r != IDLE) && !m_ready;

    fwrisc_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (wait_clr_s),
        .en      (wait_en_s),
        .expired (expired_s)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Arbitration, completion/timeout decode and requester-side responses
    always_comb begin
        next_state_s = state_r;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        done_s       = 1'b0;
        iready       = 1'b0;
        ierr         = 1'b0;
        irdata       = 32'h0000_0000;
        dready       = 1'b0;
        derr         = 1'b0;
        drdata       = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (ivalid && dvalid) begin
                    if (last_r == OWN_D) begin
                        grant_i_s    = 1'b1;
                        next_state_s = GNT_I;
                    end else begin
                        grant_d_s    = 1'b1;
                        next_state_s = GNT_D;
                    end
                end else if (dvalid) begin
                    grant_d_s    = 1'b1;
                    next_state_s = GNT_D;
                end else if (ivalid) begin
                    grant_i_s    = 1'b1;
                    next_state_s = GNT_I;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GNT_I: begin
                // m_ready takes priority over a coincident timeout
                if (m_ready) begin
                    iready       = 1'b1;
                    irdata       = m_rdata;
                    done_s       = 1'b1;
                    next_state_s = IDLE;
                end else if (expired_s) begin
                    iready       = 1'b1;
                    ierr         = 1'b1;
                    done_s       = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = GNT_I;
                end
            end
            GNT_D: begin
                if (m_ready) begin
                    dready       = 1'b1;
                    drdata       = m_rdata;
                    done_s       = 1'b1;
                    next_state_s = IDLE;
                end else if (expired_s) begin
                    dready       = 1'b1;
                    derr         = 1'b1;
                    done_s       = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = GNT_D;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Shared-bus request registers: load on grant, drop m_valid on completion
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_addr  <= 32'h0000_0000;
            m_write <= 1'b0;
            m_wdata <= 32'h0000_0000;
            m_strb  <= 4'h0;
        end else if (grant_d_s) begin
            m_valid <= 1'b1;
            m_addr  <= daddr;
            m_write <= dwrite;
            m_wdata <= dwdata;
            m_strb  <= dstrb;
        end else if (grant_i_s) begin
            m_valid <= 1'b1;
            m_addr  <= iaddr;
            m_write <= 1'b0;
            m_wdata <= 32'h0000_0000;
            m_strb  <= STRB_ALL;
        end else if (done_s) begin
            m_valid <= 1'b0;
        end else begin
            m_valid <= m_valid;
        end
    end

    // Last-grant tracking for round-robin, updated when a transaction ends
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_r <= RESET_LAST;
        end else if (done_s) begin
            last_r <= owner_of(state_r);
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: tb/tb_fwrisc_mem_arb.sv
// Self-checking bench for fwrisc_mem_arb. Directed scenarios plus randomized
// request rounds checked against a transaction-level round-robin model.
module tb_fwrisc_mem_arb;

    localparam int unsigned TMO = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] iaddr;
    logic        ivalid;
    logic [31:0] irdata;
    logic        iready;
    logic        ierr;
    logic [31:0] daddr;
    logic        dvalid;
    logic        dwrite;
    logic [31:0] dwdata;
    logic [3:0]  dstrb;
    logic [31:0] drdata;
    logic        dready;
    logic        derr;
    logic [31:0] m_addr;
    logic        m_valid;
    logic        m_write;
    logic [31:0] m_wdata;
    logic [3:0]  m_strb;
    logic [31:0] m_rdata;
    logic        m_ready;

    int n_vec = 0;
    int n_err = 0;

    fwrisc_mem_arb #(
        .TIMEOUT_CYCLES (TMO),
        .DBUS_FIRST     (1'b1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .iaddr   (iaddr),
        .ivalid  (ivalid),
        .irdata  (irdata),
        .iready  (iready),
        .ierr    (ierr),
        .daddr   (daddr),
        .dvalid  (dvalid),
        .dwrite  (dwrite),
        .dwdata  (dwdata),
        .dstrb   (dstrb),
        .drdata  (drdata),
        .dready  (dready),
        .derr    (derr),
        .m_addr  (m_addr),
        .m_valid (m_valid),
        .m_write (m_write),
        .m_wdata (m_wdata),
        .m_strb  (m_strb),
        .m_rdata (m_rdata),
        .m_ready (m_ready)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ivalid = 1'b0; dvalid = 1'b0; dwrite = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dwdata = 32'h0; dstrb = 4'h0;
        m_ready = 1'b0; m_rdata = 32'h0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ivalid = 1'b1; dvalid = 1'b1; iaddr = 32'h40; daddr = 32'h80;
        dwrite = 1'b1; dwdata = 32'hFFFF_FFFF; dstrb = 4'hf;
        m_ready = 1'b1; m_rdata = 32'h1234_5678;
        repeat (3) @(posedge clock);
        @(negedge clock);
        if ({m_valid, m_write, m_strb, iready, ierr, dready, derr} !== 10'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 0", {m_valid, m_write, m_strb, iready, ierr, dready, derr});
        end
        n_vec++;
        if ({m_addr, m_wdata, irdata, drdata} !== 128'h0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {m_addr, m_wdata, irdata, drdata});
        end
        n_vec++;
        do_reset();
    endtask

    task automatic test_single_load();
        do_reset();
        daddr = 32'h100; dvalid = 1'b1; dwrite = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 3) begin m_ready = 1'b1; m_rdata = 32'hCAFE_F00D; end
            @(negedge clock);
            if (m_valid !== 1'b1 || m_addr !== 32'h100 || m_write !== 1'b0) begin
                n_err++; $display("FAIL load_req c%0d: got v=%b a=%h w=%b want v=1 a=100 w=0", c, m_valid, m_addr, m_write);
            end
            n_vec++;
            if (dready !== (c == 3) || derr !== 1'b0 || iready !== 1'b0 || drdata !== ((c == 3) ? 32'hCAFE_F00D : 32'h0)) begin
                n_err++; $display("FAIL load_resp c%0d: got rdy=%b err=%b ir=%b d=%h", c, dready, derr, iready, drdata);
            end
            n_vec++;
        end
        step();
        m_ready = 1'b0; dvalid = 1'b0; m_rdata = 32'h0;
        @(negedge clock);
        if (m_valid !== 1'b0 || dready !== 1'b0) begin
            n_err++; $display("FAIL load_end: got v=%b rdy=%b want 0 0", m_valid, dready);
        end
        n_vec++;
    endtask

    task automatic test_arbitration();
        bit exp_d;
        bit last_d;
        do_reset();
        iaddr = 32'h0000_2000; daddr = 32'h0000_3000; dwrite = 1'b0; dstrb = 4'b0101;
        ivalid = 1'b1; dvalid = 1'b1; m_ready = 1'b1;
        last_d = 1'b0; // DBUS_FIRST=1: dbus wins the first tie
        for (int k = 0; k < 4; k++) begin
            exp_d = !last_d;
            step();
            m_rdata = $urandom;
            @(negedge clock);
            if (m_valid !== 1'b1 || dready !== exp_d || iready !== !exp_d) begin
                n_err++; $display("FAIL arb_order k%0d: got v=%b dr=%b ir=%b want dr=%b", k, m_valid, dready, iready, exp_d);
            end
            n_vec++;
            if (m_addr !== (exp_d ? 32'h3000 : 32'h2000) || m_strb !== (exp_d ? 4'b0101 : 4'hf) || m_write !== 1'b0) begin
                n_err++; $display("FAIL arb_fields k%0d: got a=%h s=%h w=%b", k, m_addr, m_strb, m_write);
            end
            n_vec++;
            if ((exp_d ? drdata : irdata) !== m_rdata || (exp_d ? irdata : drdata) !== 32'h0) begin
                n_err++; $display("FAIL arb_rdata k%0d: got i=%h d=%h want %h", k, irdata, drdata, m_rdata);
            end
            n_vec++;
            last_d = exp_d;
            step();
            @(negedge clock);
            if (m_valid !== 1'b0 || iready !== 1'b0 || dready !== 1'b0) begin
                n_err++; $display("FAIL arb_gap k%0d: got v=%b ir=%b dr=%b want 0", k, m_valid, iready, dready);
            end
            n_vec++;
        end
        ivalid = 1'b0; dvalid = 1'b0; m_ready = 1'b0;
    endtask

    task automatic test_store();
        do_reset();
        daddr = 32'h0000_0404; dvalid = 1'b1; dwrite = 1'b1; dwdata = 32'h1122_3344; dstrb = 4'b0011;
        step();
        @(negedge clock);
        if (m_valid !== 1'b1 || m_write !== 1'b1 || m_wdata !== 32'h1122_3344 || m_strb !== 4'b0011 || m_addr !== 32'h404) begin
            n_err++; $display("FAIL store_req: got v=%b w=%b wd=%h s=%b a=%h", m_valid, m_write, m_wdata, m_strb, m_addr);
        end
        n_vec++;
        // requester drops valid mid-grant; latched fields must hold
        step();
        dvalid = 1'b0; dwdata = 32'h0; dstrb = 4'h0; daddr = 32'h0;
        m_ready = 1'b1;
        @(negedge clock);
        if (m_wdata !== 32'h1122_3344 || m_strb !== 4'b0011 || dready !== 1'b1 || derr !== 1'b0) begin
            n_err++; $display("FAIL store_hold: got wd=%h s=%b rdy=%b err=%b", m_wdata, m_strb, dready, derr);
        end
        n_vec++;
        step();
        m_ready = 1'b0; dwrite = 1'b0;
    endtask

    task automatic test_timeout(input bit ready_at_limit);
        logic [31:0] rd;
        do_reset();
        rd = 32'hA5A5_0F0F;
        if (ready_at_limit) begin
            daddr = 32'h0000_0800; dvalid = 1'b1; dwrite = 1'b0;
        end else begin
            iaddr = 32'h0000_0900; ivalid = 1'b1;
        end
        m_rdata = rd;
        for (int c = 1; c <= int'(TMO); c++) begin
            step();
            if (ready_at_limit && c == int'(TMO)) m_ready = 1'b1;
            @(negedge clock);
            if (m_valid !== 1'b1) begin
                n_err++; $display("FAIL tmo_valid c%0d: got %b want 1", c, m_valid);
            end
            n_vec++;
            if (ready_at_limit) begin
                if (dready !== (c == int'(TMO)) || derr !== 1'b0 || drdata !== ((c == int'(TMO)) ? rd : 32'h0)) begin
                    n_err++; $display("FAIL tmo_coincide c%0d: got rdy=%b err=%b d=%h", c, dready, derr, drdata);
                end
            end else begin
                if (iready !== (c == int'(TMO)) || ierr !== (c == int'(TMO)) || irdata !== 32'h0 || dready !== 1'b0) begin
                    n_err++; $display("FAIL tmo_abort c%0d: got rdy=%b err=%b d=%h", c, iready, ierr, irdata);
                end
            end
            n_vec++;
        end
        step();
        ivalid = 1'b0; dvalid = 1'b0; m_ready = 1'b0;
        @(negedge clock);
        if (m_valid !== 1'b0 || iready !== 1'b0 || dready !== 1'b0) begin
            n_err++; $display("FAIL tmo_after: got v=%b ir=%b dr=%b want 0", m_valid, iready, dready);
        end
        n_vec++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        daddr = 32'h0000_0C00; dvalid = 1'b1;
        step();
        step();
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        if (m_valid !== 1'b0 || dready !== 1'b0) begin
            n_err++; $display("FAIL rstmid_drop: got v=%b rdy=%b want 0 0", m_valid, dready);
        end
        n_vec++;
        m_ready = 1'b1; m_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        if (m_valid !== 1'b0 || dready !== 1'b0 || derr !== 1'b0) begin
            n_err++; $display("FAIL rstmid_hold: got v=%b rdy=%b err=%b", m_valid, dready, derr);
        end
        n_vec++;
        @(posedge clock);
        #1 reset_n = 1'b1; m_ready = 1'b0;
        step();
        @(negedge clock);
        if (m_valid !== 1'b1 || m_addr !== 32'hC00 || dready !== 1'b0) begin
            n_err++; $display("FAIL rstmid_regrant: got v=%b a=%h rdy=%b", m_valid, m_addr, dready);
        end
        n_vec++;
        step();
        m_ready = 1'b1; m_rdata = 32'h0BAD_CAFE;
        @(negedge clock);
        if (dready !== 1'b1 || drdata !== 32'h0BAD_CAFE) begin
            n_err++; $display("FAIL rstmid_done: got rdy=%b d=%h", dready, drdata);
        end
        n_vec++;
        step();
        m_ready = 1'b0; dvalid = 1'b0;
    endtask

    task automatic test_random();
        bit last_d;
        do_reset();
        last_d = 1'b0;
        for (int r = 0; r < 40; r++) begin
            bit pend_i;
            bit pend_d;
            bit win_d;
            int lat;
            int unsigned want;
            logic [31:0] rd;
            logic [31:0] ia;
            logic [31:0] da;
            logic [31:0] wd;
            logic [3:0]  st;
            logic        wr;
            want = $urandom_range(3, 1);
            pend_i = want[0]; pend_d = want[1];
            ia = $urandom & 32'hFFFF_FFFC;
            da = $urandom & 32'hFFFF_FFFC;
            wd = $urandom;
            st = 4'($urandom_range(15, 0));
            wr = 1'($urandom_range(1, 0));
            iaddr = ia; daddr = da; dwdata = wd; dstrb = st; dwrite = wr;
            ivalid = pend_i; dvalid = pend_d;
            // idle sprinkle of m_ready while IDLE must be ignored
            m_ready = 1'($urandom_range(1, 0));
            while (pend_i || pend_d) begin
                win_d = pend_d && (!pend_i || !last_d);
                lat = $urandom_range(7, 1);
                rd = $urandom;
                for (int c = 1; c <= lat; c++) begin
                    step();
                    m_ready = (c == lat);
                    m_rdata = (c == lat) ? rd : $urandom;
                    @(negedge clock);
                    if (c == 1) begin
                        if (m_valid !== 1'b1 || m_addr !== (win_d ? da : ia) || m_write !== (win_d ? wr : 1'b0)
                            || m_strb !== (win_d ? st : 4'hf) || (win_d && m_wdata !== wd)) begin
                            n_err++; $display("FAIL rnd_req r%0d: got a=%h w=%b s=%h wd=%h want d=%b", r, m_addr, m_write, m_strb, m_wdata, win_d);
                        end
                        n_vec++;
                    end
                    if (dready !== (win_d && c == lat) || iready !== (!win_d && c == lat) || ierr !== 1'b0 || derr !== 1'b0
                        || drdata !== ((win_d && c == lat) ? rd : 32'h0) || irdata !== ((!win_d && c == lat) ? rd : 32'h0)) begin
                        n_err++; $display("FAIL rnd_resp r%0d c%0d: got ir=%b dr=%b i=%h d=%h want d=%b lat=%0d", r, c, iready, dready, irdata, drdata, win_d, lat);
                    end
                    n_vec++;
                end
                step();
                m_ready = 1'b0;
                if (win_d) begin pend_d = 1'b0; dvalid = 1'b0; end
                else begin pend_i = 1'b0; ivalid = 1'b0; end
                last_d = win_d;
                @(negedge clock);
                if (m_valid !== 1'b0 || iready !== 1'b0 || dready !== 1'b0) begin
                    n_err++; $display("FAIL rnd_idle r%0d: got v=%b ir=%b dr=%b want 0", r, m_valid, iready, dready);
                end
                n_vec++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_arbitration();
        test_store();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fwrisc_mem_arb.md
FWRISC_MEM_ARB -- requirements
Module: fwrisc_mem_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023: cycles a granted transaction may wait for m_ready before being aborted; legal range 2..65535.
REQ-002 SHALL have parameter DBUS_FIRST, default 1: after reset, the first simultaneous ibus/dbus request goes to dbus (1) or ibus (0).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have these ports, one per line (name  direction  width  meaning):
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- iaddr  in  32  instruction fetch address, word aligned.
- ivalid  in  1  fetch request.
- irdata  out  32  fetch data.
- iready  out  1  fetch completion pulse.
- ierr  out  1  fetch aborted by timeout, valid with iready.
- daddr  in  32  data address, word aligned.
- dvalid  in  1  data request.
- dwrite  in  1  data request is a store.
- dwdata  in  32  store data.
- dstrb  in  4  byte strobes.
- drdata  out  32  load data.
- dready  out  1  data completion pulse.
- derr  out  1  data access aborted by timeout, valid with dready.
- m_addr  out  32  shared memory address.
- m_valid  out  1  shared memory request.
- m_write  out  1  shared memory write.
- m_wdata  out  32  shared memory write data.
- m_strb  out  4  shared memory strobes.
- m_rdata  in  32  shared memory read data.
- m_ready  in  1  shared memory completion.

Function
REQ-005 SHALL implement FSM states IDLE, GNT_I and GNT_D.
REQ-006 IDLE: dvalid only -> GNT_D; ivalid only -> GNT_I; both -> the requester not granted last, with DBUS_FIRST choosing after reset; neither -> stay in IDLE.
REQ-007 SHALL latch the winner's addr/write/wdata/strb into m_* registers on the grant edge. Ibus grants SHALL drive m_write=0 and m_strb=4'hf.
REQ-008 SHALL assert m_valid in GNT_I/GNT_D only; m_valid SHALL rise the cycle after the request is seen in IDLE (1-cycle arbitration latency).
REQ-009 In GNT_x with m_ready=1: SHALL pulse x_ready for one cycle combinationally in that cycle, pass m_rdata to x_rdata, update last-grant to x, and return to IDLE.
REQ-010 The non-owner's ready and err SHALL stay 0; irdata/drdata SHALL be 0 when the matching ready is 0.
REQ-011 Back-to-back: a request present in the cycle after completion SHALL be arbitrated in IDLE; minimum spacing between grants is 2 cycles.
REQ-012 SHALL run a wait counter that clears on grant and increments each GNT_x cycle without m_ready.
REQ-013 Timeout: when the counter reaches TIMEOUT_CYCLES-1 without m_ready, SHALL pulse x_ready and x_err together with x_rdata=0, deassert m_valid next cycle, and return to IDLE.
REQ-014 If m_ready and the timeout coincide in the same cycle, m_ready SHALL win: normal completion, err=0.
REQ-015 Requester valid dropping mid-grant SHALL NOT cancel the transaction; latched values SHALL be held until completion or timeout.
REQ-016 m_ready in IDLE SHALL be ignored.

Reset
REQ-017 While reset_n=0: state=IDLE; m_valid=0; m_addr/m_wdata=0; m_write=0; m_strb=0; counter=0; last-grant set per DBUS_FIRST; all ready/err outputs=0.
REQ-018 Reset asserted mid-transaction SHALL drop m_valid immediately (asynchronously); no ready pulse SHALL be issued for the aborted transaction.

Structure
REQ-019 The state encoding and owner encoding (OWN_I/OWN_D) SHALL live in the shared package fwrisc_bus_pkg.
REQ-020 The wait counter and timeout compare SHALL be the sub-module fwrisc_bus_timeout (inputs clr, en; output expired).

Verification
REQ-021 Directed scenarios the bench SHALL cover:
- dvalid with daddr=0x100, m_ready after 3 cycles, m_rdata=0xCAFEF00D -> m_valid high 3 cycles, single dready with drdata=0xCAFEF00D.
- ivalid and dvalid asserted together after reset, held -> grant order D, I, D, I with DBUS_FIRST=1.
- Store: dwrite=1, dwdata=0x11223344, dstrb=4'b0011 -> m_write=1, m_wdata=0x11223344, m_strb=4'b0011.
- m_ready never asserted, TIMEOUT_CYCLES=8 -> iready and ierr pulse on the 8th grant cycle, irdata=0, m_valid low next cycle.
- m_ready arrives exactly on the timeout cycle -> normal completion with err=0.
- reset_n pulled low during GNT_D -> m_valid 0 at once, no dready; after release, FSM in IDLE and arbitrates normally.
